mem_bus_if: RTL and testbench

- Memory-side neighbour of the CPU bus: holds MAR and MDR and sequences word reads/writes to external RAM over a req/ack handshake.
- Consumes the 32-bit bus value through MAR and MDR loads.
- Produces mdr_q, which feeds the bus multiplexer's MDR input.
- The control unit pulses rd/wr and waits for done before advancing its T-step.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/mem_reg.sv | 14 +
 rtl/mem_bus_if.sv | 102 ++++++++++
 tb/tb_mem_bus_if.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory FSM states and default ack timeout for the CPU memory side.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int MEM_TO_DEFAULT = 15;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;
endpackage

// File: rtl/mem_reg.sv
// mem_reg: W-bit enable register with asynchronous active-low clear (used for MAR and MDR).
module mem_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: MAR/MDR holder sequencing word reads/writes to RAM over req/ack.
// Optional ack timeout with sticky err when MEM_TIMEOUT_EN is defined.
module mem_bus_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int TO_CYCLES = cpu_pkg::MEM_TO_DEFAULT
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd,
  input  logic              wr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mdr_q,
  output logic              done,
  output logic              busy,
  output logic              err
);
  mem_state_e        state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mar_q;
  logic              capture, mdr_en;
  logic [DATA_W-1:0] mdr_d;
  logic              unused_mar;
  mem_reg #(.W(DATA_W)) u_mar (
    .clock(clock), .clear_n(clear_n), .en(MARin), .d(bus_in), .q(mar_q)
  );
  // MDR only accepts bus loads in IDLE; read data capture wins otherwise.
  assign capture = (state_q == RD_WAIT) && mem_ack;
  assign mdr_en  = capture || (MDRin && state_q == IDLE);
  assign mdr_d   = capture ? mem_rdata : bus_in;
  mem_reg #(.W(DATA_W)) u_mdr (
    .clock(clock), .clear_n(clear_n), .en(mdr_en), .d(mdr_d), .q(mdr_q)
  );
  assign unused_mar = ^mar_q[DATA_W-1:ADDR_W];
  assign mem_addr   = mar_q[ADDR_W-1:0];
  assign mem_wdata  = mdr_q;
  assign mem_req    = state_q != IDLE;
  assign mem_we     = state_q == WR_WAIT;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, expire;
  assign expire = busy && !mem_ack && cnt_q == CW'(TO_CYCLES - 1);
  assign err    = err_q;
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = busy ? cnt_q + 1'b1 : '0;
    err_d   = err_q || expire;
    if (state_q == IDLE) state_d = rd ? RD_WAIT : wr ? WR_WAIT : IDLE;
    else if (mem_ack || expire) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
`else
  logic unused_to;
  assign unused_to = TO_CYCLES != 0;
  assign err       = 1'b0;
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (state_q == IDLE) state_d = rd ? RD_WAIT : wr ? WR_WAIT : IDLE;
    else if (mem_ack) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
`endif
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed self-checking bench for mem_bus_if; timeout steps run only under MEM_TIMEOUT_EN.
module tb_mem_bus_if;
  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] bus_in = '0;
  logic        MARin = 1'b0, MDRin = 1'b0, rd = 1'b0, wr = 1'b0, mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mdr_q;
  logic        mem_req, mem_we, done, busy, err;
  int          n_cmp = 0, n_err = 0;
  mem_bus_if dut (
    .clock(clock), .clear_n(clear_n), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .rd(rd), .wr(wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we), .mdr_q(mdr_q),
    .done(done), .busy(busy), .err(err)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #12;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mdr", mdr_q, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    tick;
    // read with ack in the first request cycle
    bus_in = 32'h0000_0055; MARin = 1'b1;
    tick;
    MARin = 1'b0; rd = 1'b1;
    tick;
    rd = 1'b0;
    chk("rd_req", 32'(mem_req), 32'd1);
    chk("rd_we", 32'(mem_we), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h055);
    chk("rd_done_early", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    mem_ack = 1'b0;
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_mdr", mdr_q, 32'hDEAD_BEEF);
    chk("rd_req_drop", 32'(mem_req), 32'd0);
    chk("rd_busy_drop", 32'(busy), 32'd0);
    tick;
    chk("rd_done_pulse", 32'(done), 32'd0);
    // write with delayed ack and an MDRin attempt mid-wait
    bus_in = 32'h1234_5678; MDRin = 1'b1;
    tick;
    MDRin = 1'b0; wr = 1'b1;
    tick;
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_req", 32'(mem_req), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_wdata", mem_wdata, 32'h1234_5678);
      chk("wr_no_done", 32'(done), 32'd0);
      MDRin = (i == 1);
      bus_in = (i == 1) ? 32'hFFFF_FFFF : 32'h1234_5678;
      tick;
    end
    MDRin = 1'b0;
    chk("wr_we_ack", 32'(mem_we), 32'd1);
    chk("wr_wdata_ack", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_mdr", mdr_q, 32'h1234_5678);
    chk("wr_req_drop", 32'(mem_req), 32'd0);
    tick;
    chk("wr_done_pulse", 32'(done), 32'd0);
    // rd and wr together: read wins
    rd = 1'b1; wr = 1'b1;
    tick;
    rd = 1'b0; wr = 1'b0;
    chk("both_req", 32'(mem_req), 32'd1);
    chk("both_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    tick;
    mem_ack = 1'b0;
    chk("both_done", 32'(done), 32'd1);
    chk("both_mdr", mdr_q, 32'hA5A5_0F0F);
    tick;
    chk("both_single_done", 32'(done), 32'd0);
    chk("both_no_write", 32'(mem_req), 32'd0);
    // rd while busy ignored, spurious ack in IDLE ignored
    rd = 1'b1;
    tick;
    chk("busy_req", 32'(mem_req), 32'd1);
    tick;
    rd = 1'b0;
    chk("busy_req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick;
    mem_ack = 1'b0;
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_mdr", mdr_q, 32'h1111_2222);
    chk("busy_no_requeue", 32'(mem_req), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_done", 32'(done), 32'd0);
    chk("idle_ack_mdr", mdr_q, 32'h1111_2222);
    // async reset two cycles into a read
    rd = 1'b1;
    tick;
    rd = 1'b0;
    tick;
    chk("abort_req_before", 32'(mem_req), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mdr", mdr_q, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick;
    mem_ack = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    tick;
    chk("abort_done2", 32'(done), 32'd0);
    chk("abort_idle", 32'(mem_req), 32'd0);
    chk("abort_mdr2", mdr_q, 32'd0);
`ifdef MEM_TIMEOUT_EN
    bus_in = 32'hCAFE_0001; MDRin = 1'b1;
    tick;
    MDRin = 1'b0; rd = 1'b1;
    tick;
    rd = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_req", 32'(mem_req), 32'd1);
      chk("to_wait_done", 32'(done), 32'd0);
      chk("to_wait_err", 32'(err), 32'd0);
      tick;
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_mdr", mdr_q, 32'hCAFE_0001);
    chk("to_idle", 32'(mem_req), 32'd0);
    tick;
    tick;
    chk("to_done_pulse", 32'(done), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("to_err_clear", 32'(err), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
`endif
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
